// File: rtl/spi_cfg_pkg.sv
// Shared framing constants, address map and FSM state type for the SPI config responder.
package spi_cfg_pkg;

  // Frame layout: {rw, addr[6:0], data[7:0]}, MSB first
  localparam int FRAME_BITS = 16;
  localparam int ADDR_BITS  = 7;
  localparam int DATA_BITS  = 8;
  localparam int RW_BIT     = 15;

  // Configuration address map
  localparam logic [6:0] MODE       = 7'h00;
  localparam logic [6:0] XSLIP      = 7'h06;
  localparam logic [6:0] CAMA_CTRL  = 7'h09;
  localparam logic [6:0] CAMA_SETUP = 7'h15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_DATA    = 3'd2,
    ST_COMMIT  = 3'd3,
    ST_WAIT_SS = 3'd4
  } spi_slv_state_t;

  // True when a 7-bit frame address maps onto an implemented register
  function automatic logic addr_in_range(input logic [ADDR_BITS-1:0] addr, input int num_regs);
    return (int'(addr) < num_regs);
  endfunction

endpackage

// File: rtl/spi_cfg_slave_in_sync.sv
// Multi-flop synchronizer for one SPI pin with optional single-cycle rise/fall pulses.
module spi_in_sync #(
  parameter int STAGES = 2,
  parameter bit EDGES  = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous pin through the synchronizer chain
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= {STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

  generate
    if (EDGES) begin : g_edge
      logic prev_q;

      // Remember the previous synchronized level for edge detection
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          prev_q <= 1'b0;
        end else begin
          prev_q <= q_o;
        end
      end

      assign rise_o = q_o & ~prev_q;
      assign fall_o = ~q_o & prev_q;
    end else begin : g_no_edge
      assign rise_o = 1'b0;
      assign fall_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spi_cfg_slave.sv
// SPI mode-0 responder for 16-bit config frames, with an 8-bit register file,
// a fabric write strobe and a registered fabric read port. SCLK is oversampled.
module spi_cfg_slave
  import spi_cfg_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int SYNC_STAGES = 2,
  parameter int REG_AW      = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_sclk,
  input  logic                 i_ss,
  input  logic                 i_mosi,
  output logic                 o_miso,
  output logic                 o_wr_stb,
  output logic [ADDR_BITS-1:0] o_wr_addr,
  output logic [DATA_BITS-1:0] o_wr_data,
  input  logic [REG_AW-1:0]    i_rd_addr,
  output logic [DATA_BITS-1:0] o_rd_data,
  output logic                 o_frame_err,
  output logic                 o_addr_err
);

  spi_slv_state_t       state_q, state_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] rx_q, rx_d;
  logic [DATA_BITS-1:0] tx_q, tx_d;
  logic                 rw_q, rw_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 miso_q, miso_d;
  logic                 err_seen_q, err_seen_d;
  logic                 frame_err_q, frame_err_d;
  logic                 addr_err_q, addr_err_d;
  logic                 wr_stb_q, wr_stb_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
  logic [DATA_BITS-1:0] rd_data_q;
  logic [DATA_BITS-1:0] regs_q [NUM_REGS];

  logic                 sclk_rise_s, sclk_fall_s, ss_rise_s, ss_fall_s, mosi_s;
  logic                 sclk_lvl_unused_s, ss_lvl_unused_s;
  logic [1:0]           mosi_edge_unused_s;
  logic [DATA_BITS-1:0] addr_byte_s;
  logic                 commit_wr_s;
  logic                 rd_ok_s;

  spi_in_sync #(.STAGES(SYNC_STAGES), .EDGES(1'b1)) u_sync_sclk (
    .clk_i(i_clk), .rst_n_i(i_rst_n), .d_i(i_sclk),
    .q_o(sclk_lvl_unused_s), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .EDGES(1'b1)) u_sync_ss (
    .clk_i(i_clk), .rst_n_i(i_rst_n), .d_i(i_ss),
    .q_o(ss_lvl_unused_s), .rise_o(ss_rise_s), .fall_o(ss_fall_s)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .EDGES(1'b0)) u_sync_mosi (
    .clk_i(i_clk), .rst_n_i(i_rst_n), .d_i(i_mosi),
    .q_o(mosi_s), .rise_o(mosi_edge_unused_s[0]), .fall_o(mosi_edge_unused_s[1])
  );

  // Header byte as it stands once the current mosi bit is shifted in
  assign addr_byte_s = {rx_q[DATA_BITS-2:0], mosi_s};

  // Next-state, shift datapath and pulse generation for the frame FSM
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    miso_d      = miso_q;
    err_seen_d  = err_seen_q;
    frame_err_d = 1'b0;
    addr_err_d  = 1'b0;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    commit_wr_s = 1'b0;

    // The commit cycle always completes, whatever ss does on that cycle
    if (state_q == ST_COMMIT) begin
      if (!rw_q) begin
        if (addr_in_range(addr_q, NUM_REGS)) begin
          commit_wr_s = 1'b1;
          wr_stb_d    = 1'b1;
          wr_addr_d   = addr_q;
          wr_data_d   = rx_q;
        end else begin
          addr_err_d = 1'b1;
        end
      end else begin
        commit_wr_s = 1'b0;
      end
    end else begin
      commit_wr_s = 1'b0;
    end

    if (ss_fall_s) begin
      // Select re-arms the frame from any state
      state_d    = ST_ADDR;
      bit_cnt_d  = 5'd0;
      rx_d       = {DATA_BITS{1'b0}};
      tx_d       = {DATA_BITS{1'b0}};
      miso_d     = 1'b0;
      err_seen_d = 1'b0;
    end else if (ss_rise_s) begin
      // Deselect wins over a coincident sclk edge, which is dropped
      state_d = ST_IDLE;
      miso_d  = 1'b0;
      if (((state_q == ST_ADDR) || (state_q == ST_DATA)) && (bit_cnt_q != 5'd0)) begin
        frame_err_d = 1'b1;
      end else begin
        frame_err_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          miso_d = 1'b0;
        end
        ST_ADDR: begin
          miso_d = 1'b0;
          if (sclk_rise_s) begin
            rx_d      = addr_byte_s;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'(DATA_BITS - 1)) begin
              state_d = ST_DATA;
              rw_d    = addr_byte_s[RW_BIT-DATA_BITS];
              addr_d  = addr_byte_s[ADDR_BITS-1:0];
              if (addr_byte_s[RW_BIT-DATA_BITS]) begin
                if (addr_in_range(addr_byte_s[ADDR_BITS-1:0], NUM_REGS)) begin
                  tx_d = regs_q[addr_byte_s[REG_AW-1:0]];
                end else begin
                  tx_d       = {DATA_BITS{1'b0}};
                  addr_err_d = 1'b1;
                end
              end else begin
                tx_d = {DATA_BITS{1'b0}};
              end
            end else begin
              state_d = ST_ADDR;
            end
          end else begin
            state_d = ST_ADDR;
          end
        end
        ST_DATA: begin
          if (sclk_rise_s) begin
            rx_d      = addr_byte_s;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'(FRAME_BITS - 1)) begin
              state_d = ST_COMMIT;
            end else begin
              state_d = ST_DATA;
            end
          end else if (sclk_fall_s) begin
            // Launch the next read bit half a period before the master samples it
            miso_d = rw_q ? tx_q[DATA_BITS-1] : 1'b0;
            tx_d   = {tx_q[DATA_BITS-2:0], 1'b0};
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_COMMIT: begin
          miso_d  = 1'b0;
          state_d = ST_WAIT_SS;
        end
        ST_WAIT_SS: begin
          miso_d = 1'b0;
          if (sclk_rise_s && !err_seen_q) begin
            frame_err_d = 1'b1;
            err_seen_d  = 1'b1;
          end else begin
            frame_err_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

  // FSM, datapath and registered output flops
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 5'd0;
      rx_q        <= {DATA_BITS{1'b0}};
      tx_q        <= {DATA_BITS{1'b0}};
      rw_q        <= 1'b0;
      addr_q      <= {ADDR_BITS{1'b0}};
      miso_q      <= 1'b0;
      err_seen_q  <= 1'b0;
      frame_err_q <= 1'b0;
      addr_err_q  <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= {ADDR_BITS{1'b0}};
      wr_data_q   <= {DATA_BITS{1'b0}};
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      err_seen_q  <= err_seen_d;
      frame_err_q <= frame_err_d;
      addr_err_q  <= addr_err_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Configuration register file, written only by a committed in-range write
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_BITS{1'b0}};
      end
    end else if (commit_wr_s) begin
      regs_q[addr_q[REG_AW-1:0]] <= rx_q;
    end
  end

  generate
    if (NUM_REGS >= (1 << REG_AW)) begin : g_rd_full
      assign rd_ok_s = 1'b1;
    end else begin : g_rd_part
      assign rd_ok_s = (int'(i_rd_addr) < NUM_REGS);
    end
  endgenerate

  // Fabric read port; a same-cycle commit shows up one cycle later
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data_q <= {DATA_BITS{1'b0}};
    end else begin
      rd_data_q <= rd_ok_s ? regs_q[i_rd_addr] : {DATA_BITS{1'b0}};
    end
  end

  assign o_miso      = miso_q;
  assign o_wr_stb    = wr_stb_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_rd_data   = rd_data_q;
  assign o_frame_err = frame_err_q;
  assign o_addr_err  = addr_err_q;

endmodule

// File: tb/tb_spi_cfg_slave.sv
// Self-checking bench for spi_cfg_slave: directed frame table, reset/coincident-edge
// sequences, then random frames against a frame-level reference model.
module tb_spi_cfg_slave;
  import spi_cfg_pkg::*;

  localparam int NREGS = 32;

  typedef struct {
    logic [15:0] f;
    int          n;
    int          stb;
    logic [6:0]  wa;
    logic [7:0]  wd;
    int          ferr;
    int          aerr;
    logic [31:0] smp;
  } vec_t;

  logic       clk, rst_n, sclk, ss, mosi;
  logic [4:0] rd_addr;
  logic       miso, wr_stb, frame_err, addr_err;
  logic [6:0] wr_addr;
  logic [7:0] wr_data, rd_data;

  int checks = 0, failures = 0;
  int half = 24;
  int n_stb = 0, n_ferr = 0, n_aerr = 0;
  logic [6:0]  last_wa = 7'h0;
  logic [7:0]  last_wd = 8'h0;
  logic [31:0] smp;
  logic [7:0]  mregs [NREGS];

  initial clk = 1'b0;
  always #1 clk = ~clk;

  spi_cfg_slave #(.NUM_REGS(32), .SYNC_STAGES(2), .REG_AW(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sclk(sclk), .i_ss(ss), .i_mosi(mosi),
    .o_miso(miso), .o_wr_stb(wr_stb), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_frame_err(frame_err), .o_addr_err(addr_err)
  );

  // Count pulse cycles so that a stretched pulse shows up as an extra event
  always @(negedge clk) begin
    if (wr_stb) begin n_stb++; last_wa = wr_addr; last_wd = wr_data; end
    if (frame_err) n_ferr++;
    if (addr_err) n_aerr++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One master bit: set mosi, sample miso as the master would, pulse sclk
  task automatic send_bit(input logic b);
    mosi = b;
    cyc(half);
    smp = {smp[30:0], miso};
    sclk = 1'b1;
    cyc(half);
    sclk = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] f, input int n, input logic extra,
                           output int d_stb, output int d_ferr, output int d_aerr);
    logic [31:0] bits;
    int s0, s1, s2;
    if (n <= 16) bits = 32'(f) >> (16 - n);
    else bits = (32'(f) << (n - 16)) | {31'h0, extra};
    s0 = n_stb; s1 = n_ferr; s2 = n_aerr;
    smp = 32'h0;
    ss = 1'b0;
    cyc(half);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
    cyc(half);
    ss = 1'b1;
    cyc(2 * half + 8);
    d_stb = n_stb - s0; d_ferr = n_ferr - s1; d_aerr = n_aerr - s2;
  endtask

  // Frame-level reference: outcome of an n-bit frame whose first 16 bits are f
  task automatic model(input logic [15:0] f, input int n, output int e_stb, output int e_ferr,
                       output int e_aerr, output logic [31:0] e_smp);
    logic       rw, inr, b;
    logic [6:0] a;
    logic [7:0] rb;
    rw  = f[15];
    a   = f[14:8];
    inr = (int'(a) < NREGS);
    rb  = inr ? mregs[a[4:0]] : 8'h00;
    e_stb  = (!rw && inr && n >= 16) ? 1 : 0;
    e_ferr = ((n >= 1 && n <= 15) || n > 16) ? 1 : 0;
    e_aerr = (!inr && ((rw && n >= 8) || (!rw && n >= 16))) ? 1 : 0;
    e_smp  = 32'h0;
    for (int k = 1; k <= n; k++) begin
      b = (rw && k >= 9 && k <= 16) ? rb[16 - k] : 1'b0;
      e_smp = {e_smp[30:0], b};
    end
    if (e_stb == 1) mregs[a[4:0]] = f[7:0];
  endtask

  task automatic rd_chk(input int a, input logic [7:0] exp, input string nm);
    rd_addr = 5'(a);
    cyc(2);
    chk(nm, {24'h0, rd_data}, {24'h0, exp});
  endtask

  initial begin
    vec_t        tbl [11];
    int          d_stb, d_ferr, d_aerr, e_stb, e_ferr, e_aerr, n;
    logic [31:0] e_smp;
    logic [15:0] f;
    logic [6:0]  a;
    logic        ex;

    tbl[0]  = '{{1'b0, MODE, 8'h03},       16, 1, MODE,       8'h03, 0, 0, 32'h0};
    tbl[1]  = '{{1'b0, CAMA_SETUP, 8'h30}, 16, 1, CAMA_SETUP, 8'h30, 0, 0, 32'h0};
    tbl[2]  = '{{1'b0, XSLIP, 8'h05},      16, 1, XSLIP,      8'h05, 0, 0, 32'h0};
    tbl[3]  = '{{1'b0, CAMA_CTRL, 8'h00},  16, 1, CAMA_CTRL,  8'h00, 0, 0, 32'h0};
    tbl[4]  = '{16'h9500,                  16, 0, 7'h00,      8'h00, 0, 0, 32'h0030};
    tbl[5]  = '{16'h8000,                  16, 0, 7'h00,      8'h00, 0, 0, 32'h0003};
    tbl[6]  = '{16'h1A00,                   8, 0, 7'h00,      8'h00, 1, 0, 32'h0};
    tbl[7]  = '{16'h7F55,                  16, 0, 7'h00,      8'h00, 0, 1, 32'h0};
    tbl[8]  = '{16'hFF00,                  16, 0, 7'h00,      8'h00, 0, 1, 32'h0};
    tbl[9]  = '{16'h0900,                  17, 1, 7'h09,      8'h00, 1, 0, 32'h0};
    tbl[10] = '{16'h8600,                  16, 0, 7'h00,      8'h00, 0, 0, 32'h0005};

    for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;
    rst_n = 1'b0; sclk = 1'b0; ss = 1'b1; mosi = 1'b0; rd_addr = 5'h00;
    cyc(3);
    chk("rst_miso", {31'h0, miso}, 32'h0);
    chk("rst_wr_stb", {31'h0, wr_stb}, 32'h0);
    chk("rst_rd_data", {24'h0, rd_data}, 32'h0);
    chk("rst_errs", {30'h0, frame_err, addr_err}, 32'h0);
    rst_n = 1'b1;
    cyc(10);

    // Directed frame table
    for (int i = 0; i < 11; i++) begin
      model(tbl[i].f, tbl[i].n, e_stb, e_ferr, e_aerr, e_smp);
      run_frame(tbl[i].f, tbl[i].n, 1'b1, d_stb, d_ferr, d_aerr);
      chk($sformatf("tbl%0d_stb", i), d_stb, tbl[i].stb);
      chk($sformatf("tbl%0d_ferr", i), d_ferr, tbl[i].ferr);
      chk($sformatf("tbl%0d_aerr", i), d_aerr, tbl[i].aerr);
      chk($sformatf("tbl%0d_miso", i), smp, tbl[i].smp);
      if (tbl[i].stb == 1) begin
        chk($sformatf("tbl%0d_wa", i), {25'h0, last_wa}, {25'h0, tbl[i].wa});
        chk($sformatf("tbl%0d_wd", i), {24'h0, last_wd}, {24'h0, tbl[i].wd});
      end
    end
    rd_chk(32'h15, 8'h30, "rd_cama_setup");
    rd_chk(32'h1A, 8'h00, "rd_1a_untouched");
    for (int i = 0; i < NREGS; i++) rd_chk(i, mregs[i], $sformatf("rd_reg%0d", i));

    // Reset in the middle of a write frame, then resend it
    rd_addr = 5'h15;
    cyc(2);
    chk("pre_rst_rd", {24'h0, rd_data}, 32'h30);
    f = {1'b0, XSLIP, 8'h05};
    ss = 1'b0;
    cyc(half);
    for (int i = 15; i >= 6; i--) send_bit(f[i]);
    d_stb = n_stb; d_ferr = n_ferr;
    rst_n = 1'b0;
    cyc(1);
    chk("mid_rst_outs", {miso, wr_stb, frame_err, addr_err}, 32'h0);
    chk("mid_rst_wr", {17'h0, wr_addr, wr_data}, 32'h0);
    chk("mid_rst_rd", {24'h0, rd_data}, 32'h0);
    cyc(2);
    rst_n = 1'b1;
    ss = 1'b1;
    cyc(2 * half + 8);
    for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;
    chk("mid_rst_no_evt", (n_stb - d_stb) + (n_ferr - d_ferr), 32'h0);
    rd_chk(6, 8'h00, "rd_xslip_after_rst");
    model(f, 16, e_stb, e_ferr, e_aerr, e_smp);
    run_frame(f, 16, 1'b0, d_stb, d_ferr, d_aerr);
    chk("resend_stb", d_stb, 32'd1);
    chk("resend_wr", {17'h0, last_wa, last_wd}, {17'h0, XSLIP, 8'h05});
    chk("resend_ferr", d_ferr, 32'd0);

    // Deselect coincident with the 16th rising edge: abort, no write
    f = {1'b0, CAMA_CTRL, 8'hAB};
    d_stb = n_stb; d_ferr = n_ferr;
    ss = 1'b0;
    cyc(half);
    for (int i = 15; i >= 1; i--) send_bit(f[i]);
    mosi = f[0];
    cyc(half);
    sclk = 1'b1;
    ss = 1'b1;
    cyc(half);
    sclk = 1'b0;
    cyc(2 * half + 8);
    chk("coinc_stb", n_stb - d_stb, 32'd0);
    chk("coinc_ferr", n_ferr - d_ferr, 32'd1);
    rd_chk(9, mregs[9], "coinc_reg9");

    // Random frames against the reference model
    for (int t = 0; t < 40; t++) begin
      half = $urandom_range(6, 20);
      if ($urandom_range(0, 9) == 0) a = 7'($urandom);
      else a = 7'($urandom_range(0, 40));
      f = {1'($urandom), a, 8'($urandom)};
      case ($urandom_range(0, 9))
        0, 1:    n = $urandom_range(1, 15);
        2:       n = $urandom_range(17, 18);
        default: n = 16;
      endcase
      ex = 1'($urandom);
      model(f, n, e_stb, e_ferr, e_aerr, e_smp);
      run_frame(f, n, ex, d_stb, d_ferr, d_aerr);
      chk($sformatf("rnd%0d_stb", t), d_stb, e_stb);
      chk($sformatf("rnd%0d_ferr", t), d_ferr, e_ferr);
      chk($sformatf("rnd%0d_aerr", t), d_aerr, e_aerr);
      chk($sformatf("rnd%0d_miso", t), smp, e_smp);
      if (e_stb == 1) chk($sformatf("rnd%0d_wr", t), {17'h0, last_wa, last_wd}, {17'h0, f[14:0]});
      n = $urandom_range(0, NREGS - 1);
      rd_chk(n, mregs[n], $sformatf("rnd%0d_rd", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
